// File: rtl/i2s_tx.sv
// Philips-format I2S transmitter: derives BCK from AMCLK and serialises a
// double-buffered stereo sample pair, MSB first, one BCK after each WS edge.
module i2s_tx #(
    parameter int I2S_DATA_BITS = 16,
    parameter int SLOT_BITS     = 16,
    parameter int BCK_DIV       = 8
) (
    input  logic                            AMCLK_i,
    input  logic                            reset,
    input  logic signed [I2S_DATA_BITS-1:0] APDATA_LEFT_i,
    input  logic signed [I2S_DATA_BITS-1:0] APDATA_RIGHT_i,
    input  logic                            APDATA_VALID_i,
    output logic                            SAMPLE_REQ_o,
    output logic                            UNDERRUN_o,
    output logic                            I2S_BCK_o,
    output logic                            I2S_WS_o,
    output logic                            I2S_DATA_o
);

    localparam int DIV_W      = $clog2(BCK_DIV);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(BCK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] DIV_FALL = DIV_W'(BCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] WS_LAST  = BIT_W'(FRAME_BITS - 2);
    localparam logic [BIT_W-1:0] SLOT_LEN = BIT_W'(SLOT_BITS);

    logic [DIV_W-1:0]         div_ctr_q, div_ctr_d;
    logic [BIT_W-1:0]         bit_ctr_q, bit_ctr_d;
    logic [I2S_DATA_BITS-1:0] hold_l_q, hold_l_d;
    logic [I2S_DATA_BITS-1:0] hold_r_q, hold_r_d;
    logic [I2S_DATA_BITS-1:0] tx_l_q, tx_l_d;
    logic [I2S_DATA_BITS-1:0] tx_r_q, tx_r_d;
    logic                     fresh_q, fresh_d;
    logic                     sreq_q, sreq_d;
    logic                     urun_q, urun_d;
    logic                     bck_q, bck_d;
    logic                     ws_q, ws_d;
    logic                     data_q, data_d;

    logic [BIT_W-1:0]         bit_next;
    logic [BIT_W-1:0]         slot_pos;
    logic [I2S_DATA_BITS-1:0] active_word;

    always_comb begin
        div_ctr_d   = div_ctr_q + DIV_W'(1);
        bit_ctr_d   = bit_ctr_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        tx_l_d      = tx_l_q;
        tx_r_d      = tx_r_q;
        fresh_d     = fresh_q;
        sreq_d      = 1'b0;
        urun_d      = 1'b0;
        bck_d       = bck_q;
        ws_d        = ws_q;
        data_d      = data_q;
        bit_next    = (bit_ctr_q == BIT_LAST) ? '0 : bit_ctr_q + BIT_W'(1);
        slot_pos    = '0;
        active_word = '0;

        if (div_ctr_q == DIV_RISE) begin
            bck_d = 1'b1;
        end

        if (div_ctr_q == DIV_FALL) begin
            bck_d     = 1'b0;
            bit_ctr_d = bit_next;
            ws_d      = (bit_next >= WS_FIRST) && (bit_next <= WS_LAST);

            // Frame load: the left MSB must leave on this same event, so the
            // serialiser below reads the freshly loaded words.
            if (bit_next == '0) begin
                tx_l_d  = hold_l_q;
                tx_r_d  = hold_r_q;
                sreq_d  = 1'b1;
                urun_d  = !fresh_q;
                fresh_d = 1'b0;
            end

            if (bit_next < SLOT_LEN) begin
                active_word = tx_l_d;
                slot_pos    = bit_next;
            end else begin
                active_word = tx_r_d;
                slot_pos    = bit_next - SLOT_LEN;
            end

            data_d = 1'b0;
            for (int i = 0; i < I2S_DATA_BITS; i++) begin
                if (slot_pos == BIT_W'(I2S_DATA_BITS - 1 - i)) begin
                    data_d = active_word[i];
                end
            end
        end

        // A strobe coinciding with a load still wins the fresh flag for the next frame.
        if (APDATA_VALID_i) begin
            hold_l_d = APDATA_LEFT_i;
            hold_r_d = APDATA_RIGHT_i;
            fresh_d  = 1'b1;
        end
    end

    always_ff @(posedge AMCLK_i or posedge reset) begin
        if (reset) begin
            div_ctr_q <= '0;
            bit_ctr_q <= BIT_LAST;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            tx_l_q    <= '0;
            tx_r_q    <= '0;
            fresh_q   <= 1'b0;
            sreq_q    <= 1'b0;
            urun_q    <= 1'b0;
            bck_q     <= 1'b0;
            ws_q      <= 1'b0;
            data_q    <= 1'b0;
        end else begin
            div_ctr_q <= div_ctr_d;
            bit_ctr_q <= bit_ctr_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            tx_l_q    <= tx_l_d;
            tx_r_q    <= tx_r_d;
            fresh_q   <= fresh_d;
            sreq_q    <= sreq_d;
            urun_q    <= urun_d;
            bck_q     <= bck_d;
            ws_q      <= ws_d;
            data_q    <= data_d;
        end
    end

    assign SAMPLE_REQ_o = sreq_q;
    assign UNDERRUN_o   = urun_q;
    assign I2S_BCK_o    = bck_q;
    assign I2S_WS_o     = ws_q;
    assign I2S_DATA_o   = data_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: a default instance plus a 24-in-32 / BCK_DIV=4
// instance, each observed by a bit-level Philips I2S receiver model.
module tb_i2s_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] left_in, right_in;
    logic        valid;
    logic        bck, ws, data, sreq, urun;
    logic [23:0] w_left_in, w_right_in;
    logic        w_valid;
    logic        w_bck, w_ws, w_data, w_sreq, w_urun;

    int vectors = 0;
    int miscompares = 0;
    int cyc;

    i2s_tx u_dut (
        .AMCLK_i(clk), .reset(rst),
        .APDATA_LEFT_i(left_in), .APDATA_RIGHT_i(right_in), .APDATA_VALID_i(valid),
        .SAMPLE_REQ_o(sreq), .UNDERRUN_o(urun),
        .I2S_BCK_o(bck), .I2S_WS_o(ws), .I2S_DATA_o(data)
    );

    i2s_tx #(.I2S_DATA_BITS(24), .SLOT_BITS(32), .BCK_DIV(4)) u_wide (
        .AMCLK_i(clk), .reset(rst),
        .APDATA_LEFT_i(w_left_in), .APDATA_RIGHT_i(w_right_in), .APDATA_VALID_i(w_valid),
        .SAMPLE_REQ_o(w_sreq), .UNDERRUN_o(w_urun),
        .I2S_BCK_o(w_bck), .I2S_WS_o(w_ws), .I2S_DATA_o(w_data)
    );

    // cyc equals k at the negedge following the k-th posedge after reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Receiver model, default instance: keep the last 16 bits, a word ends at the WS edge
    int          rx_cnt, left_cnt, right_cnt;
    logic        rx_pws;
    logic [15:0] rx_sr;
    logic [15:0] rx_left [8];
    logic [15:0] rx_right[8];

    always @(posedge bck or posedge rst) begin
        if (rst) begin
            rx_cnt = 0; left_cnt = 0; right_cnt = 0; rx_pws = 1'b0; rx_sr = '0;
        end else begin
            rx_sr = {rx_sr[14:0], data};
            if (rx_cnt < 1000) rx_cnt++;
            if (ws !== rx_pws) begin
                if (rx_cnt >= 16) begin
                    if (rx_pws == 1'b0) begin
                        if (left_cnt < 8) rx_left[left_cnt] = rx_sr;
                        left_cnt++;
                    end else begin
                        if (right_cnt < 8) rx_right[right_cnt] = rx_sr;
                        right_cnt++;
                    end
                end
                rx_cnt = 0;
            end
            rx_pws = ws;
        end
    end

    // Receiver model, wide instance: 32-bit slots, data in the top 24 bits
    int          rx2_cnt, w_left_cnt, w_right_cnt;
    logic        rx2_pws;
    logic [31:0] rx2_sr, rx2_left_slot, rx2_right_slot;

    always @(posedge w_bck or posedge rst) begin
        if (rst) begin
            rx2_cnt = 0; w_left_cnt = 0; w_right_cnt = 0; rx2_pws = 1'b0; rx2_sr = '0;
        end else begin
            rx2_sr = {rx2_sr[30:0], w_data};
            if (rx2_cnt < 1000) rx2_cnt++;
            if (w_ws !== rx2_pws) begin
                if (rx2_cnt >= 32) begin
                    if (rx2_pws == 1'b0) begin
                        if (w_left_cnt == 0) rx2_left_slot = rx2_sr;
                        w_left_cnt++;
                    end else begin
                        if (w_right_cnt == 0) rx2_right_slot = rx2_sr;
                        w_right_cnt++;
                    end
                end
                rx2_cnt = 0;
            end
            rx2_pws = w_ws;
        end
    end

    // Pulse/edge bookkeeping sampled mid-cycle
    int   sreq_cnt, urun_cnt, sreq_last, sreq_prev;
    int   ws_tog, ws_tog_last, ws_tog_prev, data_ones;
    logic mon_pws;
    int   w_sreq_cnt, w_urun_cnt, w_sreq_last, w_sreq_prev, w_viol;
    logic w_pws, w_pdata;

    always @(negedge clk) begin
        if (sreq === 1'b1) begin sreq_cnt++; sreq_prev = sreq_last; sreq_last = cyc; end
        if (urun === 1'b1) urun_cnt++;
        if (ws !== mon_pws) begin ws_tog++; ws_tog_prev = ws_tog_last; ws_tog_last = cyc; end
        mon_pws = ws;
        if (data === 1'b1) data_ones++;
        if (w_sreq === 1'b1) begin w_sreq_cnt++; w_sreq_prev = w_sreq_last; w_sreq_last = cyc; end
        if (w_urun === 1'b1) w_urun_cnt++;
        if (w_bck === 1'b1 && (w_ws !== w_pws || w_data !== w_pdata)) w_viol++;
        w_pws = w_ws;
        w_pdata = w_data;
    end

    task automatic do_reset();
        rst = 1'b1;
        valid = 1'b0; left_in = '0; right_in = '0;
        w_valid = 1'b0; w_left_in = '0; w_right_in = '0;
        @(negedge clk);
        #1;
        sreq_cnt = 0; urun_cnt = 0; sreq_last = 0; sreq_prev = 0;
        ws_tog = 0; ws_tog_last = 0; ws_tog_prev = 0; data_ones = 0; mon_pws = 1'b0;
        w_sreq_cnt = 0; w_urun_cnt = 0; w_sreq_last = 0; w_sreq_prev = 0; w_viol = 0;
        w_pws = 1'b0; w_pdata = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        for (int i = 0; i < 5000 && cyc < k; i++) @(negedge clk);
    endtask

    task automatic wait_right(input int n, output bit timed_out);
        for (int i = 0; i < 3000 && right_cnt < n; i++) @(negedge clk);
        timed_out = (right_cnt < n);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 1'b0; w_valid = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bck !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_bck: got %b want 0", bck); end
        vectors++; if (ws !== 1'b0)   begin miscompares++; $display("[TB] FAIL reset_ws: got %b want 0", ws); end
        vectors++; if (data !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_data: got %b want 0", data); end
        vectors++; if (sreq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sreq: got %b want 0", sreq); end
        vectors++; if (urun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_urun: got %b want 0", urun); end
    endtask

    task automatic test_basic_frame();
        bit to;
        do_reset();
        left_in = 16'hA5C3; right_in = 16'h0F01; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_cyc(7);
        vectors++; if (sreq !== 1'b0) begin miscompares++; $display("[TB] FAIL pre_load_sreq: got %b want 0", sreq); end
        vectors++; if (data !== 1'b0) begin miscompares++; $display("[TB] FAIL pre_load_data: got %b want 0", data); end
        @(negedge clk);
        vectors++; if (sreq !== 1'b1) begin miscompares++; $display("[TB] FAIL load_sreq: got %b want 1", sreq); end
        vectors++; if (ws !== 1'b0)   begin miscompares++; $display("[TB] FAIL load_ws: got %b want 0", ws); end
        vectors++; if (data !== 1'b1) begin miscompares++; $display("[TB] FAIL load_msb: got %b want 1", data); end
        @(negedge clk);
        vectors++; if (sreq !== 1'b0) begin miscompares++; $display("[TB] FAIL sreq_width: got %b want 0", sreq); end
        wait_right(1, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_timeout: got %b want 0", to); end
        vectors++; if (rx_left[0] !== 16'hA5C3)  begin miscompares++; $display("[TB] FAIL basic_left: got %h want a5c3", rx_left[0]); end
        vectors++; if (rx_right[0] !== 16'h0F01) begin miscompares++; $display("[TB] FAIL basic_right: got %h want 0f01", rx_right[0]); end
        vectors++; if (urun_cnt !== 0) begin miscompares++; $display("[TB] FAIL basic_urun: got %0d want 0", urun_cnt); end
    endtask

    task automatic test_underrun();
        do_reset();
        wait_cyc(600);
        vectors++; if (urun_cnt !== 3) begin miscompares++; $display("[TB] FAIL urun_count: got %0d want 3", urun_cnt); end
        vectors++; if (sreq_cnt !== 3) begin miscompares++; $display("[TB] FAIL sreq_count: got %0d want 3", sreq_cnt); end
        vectors++; if (sreq_last - sreq_prev !== 256) begin miscompares++; $display("[TB] FAIL sreq_period: got %0d want 256", sreq_last - sreq_prev); end
        vectors++; if (ws_tog !== 4) begin miscompares++; $display("[TB] FAIL ws_toggles: got %0d want 4", ws_tog); end
        vectors++; if (ws_tog_last - ws_tog_prev !== 128) begin miscompares++; $display("[TB] FAIL ws_spacing: got %0d want 128", ws_tog_last - ws_tog_prev); end
        vectors++; if (ws_tog_last !== 512) begin miscompares++; $display("[TB] FAIL ws_phase: got %0d want 512", ws_tog_last); end
        vectors++; if (data_ones !== 0) begin miscompares++; $display("[TB] FAIL urun_data: got %0d want 0", data_ones); end
        vectors++; if (right_cnt < 1) begin miscompares++; $display("[TB] FAIL urun_frames: got %0d want >=1", right_cnt); end
        vectors++; if (rx_left[0] !== 16'h0000) begin miscompares++; $display("[TB] FAIL urun_left: got %h want 0000", rx_left[0]); end
    endtask

    task automatic test_load_cycle_strobe();
        bit to;
        do_reset();
        left_in = 16'hAAAA; right_in = 16'h5555; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_cyc(263);
        left_in = 16'h1234; right_in = 16'h5678; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        vectors++; if (urun !== 1'b1) begin miscompares++; $display("[TB] FAIL lc_urun_pulse: got %b want 1", urun); end
        wait_right(3, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL lc_timeout: got %b want 0", to); end
        vectors++; if (rx_left[1] !== 16'hAAAA)  begin miscompares++; $display("[TB] FAIL lc_old_left: got %h want aaaa", rx_left[1]); end
        vectors++; if (rx_right[1] !== 16'h5555) begin miscompares++; $display("[TB] FAIL lc_old_right: got %h want 5555", rx_right[1]); end
        vectors++; if (rx_left[2] !== 16'h1234)  begin miscompares++; $display("[TB] FAIL lc_new_left: got %h want 1234", rx_left[2]); end
        vectors++; if (rx_right[2] !== 16'h5678) begin miscompares++; $display("[TB] FAIL lc_new_right: got %h want 5678", rx_right[2]); end
        vectors++; if (urun_cnt !== 1) begin miscompares++; $display("[TB] FAIL lc_urun_count: got %0d want 1", urun_cnt); end
    endtask

    task automatic test_back_to_back();
        bit to;
        do_reset();
        left_in = 16'h1111; right_in = 16'hEEEE; valid = 1'b1;
        @(negedge clk);
        left_in = 16'h2222; right_in = 16'hDDDD;
        @(negedge clk);
        left_in = 16'h3333; right_in = 16'hCCCC;
        @(negedge clk);
        valid = 1'b0;
        wait_right(1, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_timeout: got %b want 0", to); end
        vectors++; if (rx_left[0] !== 16'h3333)  begin miscompares++; $display("[TB] FAIL b2b_left: got %h want 3333", rx_left[0]); end
        vectors++; if (rx_right[0] !== 16'hCCCC) begin miscompares++; $display("[TB] FAIL b2b_right: got %h want cccc", rx_right[0]); end
        vectors++; if (urun_cnt !== 0) begin miscompares++; $display("[TB] FAIL b2b_urun: got %0d want 0", urun_cnt); end
    endtask

    task automatic test_mid_frame_reset();
        bit to;
        do_reset();
        left_in = 16'hBEEF; right_in = 16'hCAFE; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_cyc(194);
        vectors++; if (ws !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_in_right: got %b want 1", ws); end
        rst = 1'b1;
        #1;
        vectors++; if (bck !== 1'b0)  begin miscompares++; $display("[TB] FAIL mid_rst_bck: got %b want 0", bck); end
        vectors++; if (ws !== 1'b0)   begin miscompares++; $display("[TB] FAIL mid_rst_ws: got %b want 0", ws); end
        vectors++; if (data !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_data: got %b want 0", data); end
        do_reset();
        left_in = 16'h7E57; right_in = 16'h1DEA; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        wait_right(1, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_timeout: got %b want 0", to); end
        vectors++; if (left_cnt !== 1) begin miscompares++; $display("[TB] FAIL mid_left_words: got %0d want 1", left_cnt); end
        vectors++; if (rx_left[0] !== 16'h7E57)  begin miscompares++; $display("[TB] FAIL mid_left: got %h want 7e57", rx_left[0]); end
        vectors++; if (rx_right[0] !== 16'h1DEA) begin miscompares++; $display("[TB] FAIL mid_right: got %h want 1dea", rx_right[0]); end
    endtask

    task automatic test_wide_slot();
        do_reset();
        w_left_in = 24'hABCDEF; w_right_in = 24'h123456; w_valid = 1'b1;
        @(negedge clk);
        w_valid = 1'b0;
        for (int i = 0; i < 3000 && (w_right_cnt < 1 || cyc < 262); i++) @(negedge clk);
        vectors++; if (w_right_cnt < 1) begin miscompares++; $display("[TB] FAIL wide_timeout: got %0d want >=1", w_right_cnt); end
        vectors++; if (rx2_left_slot[31:8] !== 24'hABCDEF) begin miscompares++; $display("[TB] FAIL wide_left: got %h want abcdef", rx2_left_slot[31:8]); end
        vectors++; if (rx2_left_slot[7:0] !== 8'h00) begin miscompares++; $display("[TB] FAIL wide_left_pad: got %h want 00", rx2_left_slot[7:0]); end
        vectors++; if (rx2_right_slot[31:8] !== 24'h123456) begin miscompares++; $display("[TB] FAIL wide_right: got %h want 123456", rx2_right_slot[31:8]); end
        vectors++; if (rx2_right_slot[7:0] !== 8'h00) begin miscompares++; $display("[TB] FAIL wide_right_pad: got %h want 00", rx2_right_slot[7:0]); end
        vectors++; if (w_viol !== 0) begin miscompares++; $display("[TB] FAIL wide_stable: got %0d want 0", w_viol); end
        vectors++; if (w_sreq_cnt !== 2) begin miscompares++; $display("[TB] FAIL wide_sreq_count: got %0d want 2", w_sreq_cnt); end
        vectors++; if (w_sreq_last - w_sreq_prev !== 256) begin miscompares++; $display("[TB] FAIL wide_frame: got %0d want 256", w_sreq_last - w_sreq_prev); end
        vectors++; if (w_urun_cnt !== 1) begin miscompares++; $display("[TB] FAIL wide_urun: got %0d want 1", w_urun_cnt); end
    endtask

    initial begin
        rst = 1'b1;
        valid = 1'b0; left_in = '0; right_in = '0;
        w_valid = 1'b0; w_left_in = '0; w_right_in = '0;
        test_reset();
        test_basic_frame();
        test_underrun();
        test_load_cycle_strobe();
        test_back_to_back();
        test_mid_frame_reset();
        test_wide_slot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter I2S_DATA_BITS, default 16, sample word width in bits.
REQ-002 SHALL have parameter SLOT_BITS, default 16, BCK cycles per channel slot; SHALL be >= I2S_DATA_BITS.
REQ-003 SHALL have parameter BCK_DIV, default 8, AMCLK cycles per BCK period; SHALL be a power of 2 and >= 2.
REQ-004 AMCLK_i  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 APDATA_LEFT_i  input  I2S_DATA_BITS  signed left sample.
REQ-007 APDATA_RIGHT_i  input  I2S_DATA_BITS  signed right sample.
REQ-008 APDATA_VALID_i  input  1  one-cycle strobe; both sample inputs valid this cycle.
REQ-009 SAMPLE_REQ_o  output  1  one-cycle pulse; holding register consumed, next pair may be written.
REQ-010 UNDERRUN_o  output  1  one-cycle pulse; frame started without a fresh pair.
REQ-011 I2S_BCK_o  output  1  bit clock, AMCLK/BCK_DIV, 50 % duty.
REQ-012 I2S_WS_o  output  1  word select; 0 = left, 1 = right.
REQ-013 I2S_DATA_o  output  1  serial data, MSB first, Philips I2S format.

Function
REQ-014 SHALL keep div_ctr (log2(BCK_DIV) bits), incrementing every cycle, wrapping BCK_DIV-1 -> 0.
REQ-015 SHALL register all outputs; every effect below is visible the cycle after its trigger cycle.
REQ-016 Trigger div_ctr == BCK_DIV/2-1 SHALL set I2S_BCK_o to 1 (rising edge).
REQ-017 Trigger div_ctr == BCK_DIV-1 ("falling event") SHALL set I2S_BCK_o to 0 and advance bit_ctr, range 0..2*SLOT_BITS-1, wrapping to 0.
REQ-018 I2S_WS_o and I2S_DATA_o SHALL change only on falling events, so they are stable at every BCK rising edge.
REQ-019 For new bit_ctr b: I2S_WS_o SHALL be 1 for SLOT_BITS-1 <= b <= 2*SLOT_BITS-2, else 0 (WS leads slot MSB by one BCK).
REQ-020 For slot position p = b mod SLOT_BITS: I2S_DATA_o SHALL carry bit [I2S_DATA_BITS-1-p] of the active word (left for b < SLOT_BITS, right otherwise) when p < I2S_DATA_BITS, else 0.
REQ-021 Falling event with new b == 0 ("frame load") SHALL copy holding L/R into the transmit words; the MSB of left goes out on that same event.
REQ-022 APDATA_VALID_i high SHALL write both inputs into the holding L/R registers and set a fresh flag.
REQ-023 Frame load SHALL clear the fresh flag and pulse SAMPLE_REQ_o for exactly one cycle.
REQ-024 Frame load with fresh flag clear SHALL also pulse UNDERRUN_o and retransmit the previous holding contents.
REQ-025 APDATA_VALID_i in the frame-load trigger cycle: the load SHALL use the old holding contents; the new pair SHALL be stored and the fresh flag left set for the next frame.
REQ-026 Two or more valid strobes between frame loads SHALL leave the latest pair in holding, with no error indication.
REQ-027 With defaults, the frame SHALL be 256 AMCLK cycles (fs = AMCLK/256); SAMPLE_REQ_o period SHALL be exactly BCK_DIV*2*SLOT_BITS cycles.

Reset
REQ-028 reset high SHALL asynchronously force: div_ctr = 0, bit_ctr = 2*SLOT_BITS-1, holding and transmit words = 0, fresh flag = 0, all outputs 0.
REQ-029 After deassertion, the first frame load SHALL occur on the first falling event, i.e. I2S_WS_o/I2S_DATA_o start the left slot BCK_DIV cycles after reset release.
REQ-030 reset asserted mid-frame SHALL abort the frame immediately; the next frame SHALL restart cleanly per REQ-029, with no partial word.

Verification
REQ-031 Defaults, one valid strobe L=16'hA5C3, R=16'h0F01 before the first load -> receiver model captures L=A5C3, R=0F01; no UNDERRUN_o in that frame.
REQ-032 No valid strobes after reset -> UNDERRUN_o and SAMPLE_REQ_o pulse every 256 cycles; DATA all zeros; WS toggles every 16 BCKs, one BCK before each MSB.
REQ-033 Valid strobe in the frame-load trigger cycle with L=16'h1234 -> current frame sends the old pair; next frame sends 1234 with no underrun.
REQ-034 Three strobes (0x1111, 0x2222, 0x3333) within one frame -> next frame sends 0x3333 only.
REQ-035 Reset pulsed at bit_ctr 7 of a right slot -> outputs 0 within the reset; the first post-reset word is a complete left word.
REQ-036 BCK_DIV=4, SLOT_BITS=32, I2S_DATA_BITS=24 -> 24 data bits then 8 zero bits per slot; frame = 256 cycles; WS/DATA never change while BCK_o is high.
